// File: rtl/moving_average_filter_pkg.sv
// Shared types and defaults for the boxcar averaging filter.
package avg_pkg;

    localparam int unsigned DEF_WIDTH  = 12;
    localparam int unsigned DEF_N_LOG2 = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        UPDATE = 2'd2
    } state_t;

    // Running-sum width: a full window of maximum codes fits exactly.
    function automatic int unsigned sum_width(input int unsigned width, input int unsigned n_log2);
        return width + n_log2;
    endfunction

endpackage

// File: rtl/moving_average_filter_if.sv
// Sample strobe in, averaged code out.
interface moving_average_filter_if #(
    parameter int unsigned WIDTH = avg_pkg::DEF_WIDTH
);
    logic             en;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] avg_out;
    logic             avg_valid;
    logic             busy;

    modport master (output en, din, input avg_out, avg_valid, busy);
    modport slave  (input en, din, output avg_out, avg_valid, busy);
endinterface

// File: rtl/moving_average_filter_sample_ram.sv
// Sample history: simple dual-port RAM, synchronous read, no reset (block-RAM friendly).
module sample_ram #(
    parameter int unsigned WIDTH  = 12,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/moving_average_filter.sv
// Boxcar filter: running sum over the last 2^N_LOG2 strobed samples, output sum >> N_LOG2.
module moving_average_filter
    import avg_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned N_LOG2 = DEF_N_LOG2
) (
    input  logic clk,
    input  logic reset_n,
    moving_average_filter_if.slave bus
);
    localparam int unsigned SUM_W = sum_width(WIDTH, N_LOG2);
    localparam int unsigned CNT_W = N_LOG2 + 1;

    state_t state_q, state_d;

    logic [WIDTH-1:0]  din_q, old_q, ram_rdata, old_c;
    logic [SUM_W-1:0]  sum_q, sum_c;
    logic [N_LOG2-1:0] wr_ptr;
    logic [CNT_W-1:0]  fill_cnt, fill_cnt_c;
    logic [WIDTH-1:0]  avg_out_q;
    logic              avg_valid_q, busy_q;
    logic              ram_re_c, ram_we_c, ld_din_c, ld_old_c;

    // fill_cnt MSB set means the window is full; until then RAM contents are stale.
    assign old_c      = fill_cnt[N_LOG2] ? old_q : '0;
    assign sum_c      = sum_q + SUM_W'(din_q) - SUM_W'(old_c);
    assign fill_cnt_c = fill_cnt[N_LOG2] ? fill_cnt : fill_cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        ram_re_c = 1'b0;
        ram_we_c = 1'b0;
        ld_din_c = 1'b0;
        ld_old_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.en) begin
                    ld_din_c = 1'b1;
                    ram_re_c = 1'b1;
                    state_d  = READ;
                end
            end
            READ: begin
                ld_old_c = 1'b1;
                state_d  = UPDATE;
            end
            UPDATE: begin
                ram_we_c = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            din_q       <= '0;
            old_q       <= '0;
            sum_q       <= '0;
            wr_ptr      <= '0;
            fill_cnt    <= '0;
            avg_out_q   <= '0;
            avg_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            busy_q <= (state_d != IDLE);
            if (ld_din_c) din_q <= bus.din;
            if (ld_old_c) old_q <= ram_rdata;
            if (ram_we_c) begin
                sum_q       <= sum_c;
                avg_out_q   <= sum_c[SUM_W-1:N_LOG2];
                wr_ptr      <= wr_ptr + N_LOG2'(1);
                fill_cnt    <= fill_cnt_c;
                avg_valid_q <= avg_valid_q | fill_cnt_c[N_LOG2];
            end
        end
    end

    // Read and write share wr_ptr but occur in different states.
    sample_ram #(
        .WIDTH (WIDTH),
        .ADDR_W(N_LOG2)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we_c),
        .waddr(wr_ptr),
        .wdata(din_q),
        .re   (ram_re_c),
        .raddr(wr_ptr),
        .rdata(ram_rdata)
    );

    assign bus.avg_out   = avg_out_q;
    assign bus.avg_valid = avg_valid_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_moving_average_filter.sv
// Bench for moving_average_filter: directed scenarios plus a random scoreboard against a window model.
module tb_moving_average_filter;

    localparam int unsigned WIDTH  = 12;
    localparam int unsigned N_LOG2 = 8;
    localparam int unsigned N      = 256;

    logic clk;
    logic reset_n;

    int n_cmp;
    int n_err;

    // Reference model: the accepted samples still inside the window.
    int unsigned win[$];
    int unsigned n_acc;

    moving_average_filter_if #(.WIDTH(WIDTH)) bus ();

    moving_average_filter #(
        .WIDTH (WIDTH),
        .N_LOG2(N_LOG2)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    function automatic int unsigned model_avg();
        int unsigned s;
        s = 0;
        foreach (win[i]) s += win[i];
        return s / N;
    endfunction

    task automatic model_clear();
        win.delete();
        n_acc = 0;
    endtask

    task automatic model_push(input int unsigned v);
        win.push_back(v);
        if (win.size() > N) void'(win.pop_front());
        n_acc++;
    endtask

    task automatic do_reset(input int cycles);
        reset_n = 1'b0;
        bus.en  = 1'b0;
        bus.din = '0;
        repeat (cycles) @(posedge clk);
        #5 reset_n = 1'b1;
        @(posedge clk); #1;
        model_clear();
    endtask

    // Strobe one sample and check busy, the 3-clock latency and the resulting average.
    task automatic accept(input int unsigned v);
        logic [WIDTH-1:0] prev;
        int unsigned      exp_avg;
        logic             exp_valid;
        prev = bus.avg_out;
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL idle_before_strobe: busy=%0b required 0", bus.busy);
        end
        bus.en  = 1'b1;
        bus.din = WIDTH'(v);
        @(posedge clk); #1;
        bus.en = 1'b0;
        model_push(v);
        exp_avg   = model_avg();
        exp_valid = (n_acc >= N);
        n_cmp++;
        if (bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL busy_after_accept: busy=%0b required 1", bus.busy);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (bus.avg_out !== prev) begin
            n_err++;
            $display("FAIL early_update: avg_out=%0d required %0d", bus.avg_out, prev);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (bus.avg_out !== WIDTH'(exp_avg) || bus.avg_valid !== exp_valid || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL avg_update: sample %0d avg_out=%0d valid=%0b busy=%0b required %0d/%0b/0",
                     n_acc, bus.avg_out, bus.avg_valid, bus.busy, exp_avg, exp_valid);
        end
    endtask

    task automatic test_reset();
        do_reset(6);
        n_cmp++;
        if (bus.avg_out !== '0 || bus.avg_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: avg_out=%0d valid=%0b busy=%0b required 0/0/0",
                     bus.avg_out, bus.avg_valid, bus.busy);
        end
    endtask

    task automatic test_constant_fill();
        for (int i = 1; i <= 256; i++) begin
            accept(100);
            if (i == 1 || i == 128 || i == 256) begin
                n_cmp++;
                if ((i == 1   && bus.avg_out !== 12'd0) ||
                    (i == 128 && bus.avg_out !== 12'd50) ||
                    (i == 256 && (bus.avg_out !== 12'd100 || bus.avg_valid !== 1'b1))) begin
                    n_err++;
                    $display("FAIL fill_milestone: sample %0d avg_out=%0d valid=%0b", i, bus.avg_out, bus.avg_valid);
                end
            end
            if (i == 255) begin
                n_cmp++;
                if (bus.avg_valid !== 1'b0) begin
                    n_err++;
                    $display("FAIL valid_early: avg_valid=%0b required 0 at sample 255", bus.avg_valid);
                end
            end
            repeat (7) @(posedge clk);
            #1;
        end
    endtask

    task automatic test_step_wrap();
        logic [WIDTH-1:0] prev;
        prev = bus.avg_out;
        for (int i = 1; i <= 256; i++) begin
            accept(4095);
            n_cmp++;
            if (bus.avg_out < prev) begin
                n_err++;
                $display("FAIL step_monotonic: sample %0d avg_out=%0d below previous %0d", i, bus.avg_out, prev);
            end
            prev = bus.avg_out;
            if (i == 64) begin
                n_cmp++;
                if (bus.avg_out !== 12'd1098) begin
                    n_err++;
                    $display("FAIL step_midpoint: avg_out=%0d required 1098", bus.avg_out);
                end
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        n_cmp++;
        if (bus.avg_out !== 12'd4095 || bus.avg_valid !== 1'b1) begin
            n_err++;
            $display("FAIL step_final: avg_out=%0d valid=%0b required 4095/1", bus.avg_out, bus.avg_valid);
        end
    endtask

    task automatic test_busy_drop();
        int busy_cycles;
        int unsigned exp_avg;
        bus.en  = 1'b1;
        bus.din = 12'd200;
        @(posedge clk); #1;
        bus.din = 12'd300;
        model_push(200);
        @(posedge clk); #1;
        bus.en = 1'b0;
        busy_cycles = 2;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (bus.busy === 1'b1) busy_cycles++;
        end
        exp_avg = model_avg();
        n_cmp++;
        if (busy_cycles !== 2) begin
            n_err++;
            $display("FAIL busy_width: busy high %0d cycles required 2", busy_cycles);
        end
        n_cmp++;
        if (bus.avg_out !== WIDTH'(exp_avg)) begin
            n_err++;
            $display("FAIL busy_drop: avg_out=%0d required %0d", bus.avg_out, exp_avg);
        end
    endtask

    task automatic test_reset_mid_op();
        do_reset(3);
        for (int i = 0; i < 40; i++) accept(1000);
        bus.en  = 1'b1;
        bus.din = 12'd500;
        @(posedge clk); #1;
        bus.en = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.avg_out !== 12'd156) begin
            n_err++;
            $display("FAIL pre_reset_read: busy=%0b avg_out=%0d required 1/156", bus.busy, bus.avg_out);
        end
        #3 reset_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.avg_out !== '0 || bus.avg_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: avg_out=%0d valid=%0b busy=%0b required 0/0/0",
                     bus.avg_out, bus.avg_valid, bus.busy);
        end
        repeat (2) @(posedge clk);
        #5 reset_n = 1'b1;
        @(posedge clk); #1;
        model_clear();
        for (int i = 0; i < 256; i++) accept(7);
        n_cmp++;
        if (bus.avg_out !== 12'd7 || bus.avg_valid !== 1'b1) begin
            n_err++;
            $display("FAIL refill_after_reset: avg_out=%0d valid=%0b required 7/1", bus.avg_out, bus.avg_valid);
        end
    endtask

    task automatic test_random_scoreboard();
        for (int i = 0; i < 2000; i++) begin
            accept($urandom_range(0, 4095));
            repeat ($urandom_range(0, 4)) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        n_acc   = 0;
        reset_n = 1'b0;
        bus.en  = 1'b0;
        bus.din = '0;
        test_reset();
        test_constant_fill();
        test_step_wrap();
        test_busy_drop();
        test_reset_mid_op();
        test_random_scoreboard();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
